// File: rtl/aes_pkg.sv
// Shared constants, frame-size helpers and FSM state type for the AES SPI front end.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } link_state_e;

    function automatic int unsigned aes_frame_w(input int unsigned nk);
        return nk * AES_WORD_W + AES_BLOCK_W;
    endfunction

    // Only AES-128/192/256 key sizes are supported.
    function automatic bit aes_nk_legal(input int unsigned nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin with rise/fall pulses on the synced level.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/aes_spi_frame_link.sv
// SPI-slave frame receiver for the AES core: captures key+plaintext per chip-select
// and returns the previous ciphertext on SDO during the next frame.
module aes_spi_frame_link
    import aes_pkg::*;
#(
    parameter int unsigned NK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_sdi,
    output logic                     spi_sdo,
    output logic [NK*AES_WORD_W-1:0] key_o,
    output logic [AES_BLOCK_W-1:0]   block_o,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    input  logic [AES_BLOCK_W-1:0]   res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic                     err_len,
    output logic                     err_overrun
);

    localparam int unsigned KEY_W   = NK * AES_WORD_W;
    localparam int unsigned FRAME_W = aes_frame_w(NK);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam bit NK_OK = aes_nk_legal(NK);

    if (!NK_OK) begin : g_bad_nk
        $error("aes_spi_frame_link: NK must be 4, 6 or 8");
    end

    logic unused_sclk_lvl;
    logic sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic sdi_meta, sdi_q;

    spi_sync_edge u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi_sclk),
        .q      (unused_sclk_lvl),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync_edge u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi_cs_n),
        .q      (cs_q),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    // sdi shares the sclk synchroniser depth so it lines up with the detected rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdi_meta <= 1'b0;
            sdi_q    <= 1'b0;
        end else begin
            sdi_meta <= spi_sdi;
            sdi_q    <= sdi_meta;
        end
    end

    link_state_e             state;
    logic [CNT_W-1:0]        bitcnt;
    logic [FRAME_W-1:0]      rx_shift;
    logic [AES_BLOCK_W-1:0]  tx_shift;
    logic [AES_BLOCK_W-1:0]  tx_buf;
    logic                    tx_full;
    logic                    ending;

    logic load, start, tx_full_n, shift_n;

    assign load      = res_valid && res_ready;
    assign start     = (state == ST_IDLE) && cs_fall;
    // A load coinciding with a frame start wins: that frame reads zeros, the result waits.
    assign tx_full_n = load ? 1'b1 : (start ? 1'b0 : tx_full);
    assign shift_n   = start || ((state == ST_SHIFT) && !cs_rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ARM;
            bitcnt      <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            ending      <= 1'b0;
            spi_sdo     <= 1'b0;
            key_o       <= '0;
            block_o     <= '0;
            frame_valid <= 1'b0;
            res_ready   <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
            ending      <= 1'b0;
            res_ready   <= !tx_full_n && !shift_n;

            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            // Judge the frame one cycle after chip-select release.
            if (ending) begin
                if (bitcnt != CNT_FULL) begin
                    err_len <= 1'b1;
                end else if (frame_valid) begin
                    err_overrun <= 1'b1;
                end else begin
                    key_o       <= rx_shift[FRAME_W-1 -: KEY_W];
                    block_o     <= rx_shift[AES_BLOCK_W-1:0];
                    frame_valid <= 1'b1;
                end
            end

            case (state)
                ST_ARM: begin
                    if (cs_q) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        bitcnt   <= '0;
                        tx_shift <= tx_full ? tx_buf : '0;
                        spi_sdo  <= tx_full & tx_buf[AES_BLOCK_W-1];
                        tx_full  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state   <= ST_IDLE;
                        ending  <= 1'b1;
                        spi_sdo <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[FRAME_W-2:0], sdi_q};
                            if (bitcnt != CNT_SAT) begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[AES_BLOCK_W-2:0], 1'b0};
                            spi_sdo  <= tx_shift[AES_BLOCK_W-2];
                        end
                    end
                end
                default: state <= ST_ARM;
            endcase

            if (load) begin
                tx_buf  <= res_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule
